// File: rtl/systolic_pkg.sv
// Shared types and limits for the systolic array edge feeder.
package systolic_pkg;

    // Minimum cycles a PE needs between consecutive operand beats.
    localparam int unsigned MIN_PE_TURNAROUND = 4;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane wavefront delay line of {data, valid, last}; advances only when shift_en_i is high.
module skew_delay_line #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  shift_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    output logic [DATA_WIDTH-1:0] tap_data_o,
    output logic                  tap_valid_o,
    output logic                  tap_last_o
);

    localparam int D = int'(DEPTH);

    if (D == 0) begin : g_wire
        assign tap_data_o  = data_i;
        assign tap_valid_o = valid_i;
        assign tap_last_o  = last_i;

        logic unused_ok;
        assign unused_ok = ^{clk_i, rstn_i, shift_en_i};
    end else begin : g_shift
        logic [DATA_WIDTH-1:0] data_q [D];
        logic [D-1:0]          valid_q;
        logic [D-1:0]          last_q;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                for (int i = 0; i < D; i++) begin
                    data_q[i] <= '0;
                end
                valid_q <= '0;
                last_q  <= '0;
            end else if (shift_en_i) begin
                data_q[0]  <= data_i;
                valid_q[0] <= valid_i;
                last_q[0]  <= last_i;
                for (int i = 1; i < D; i++) begin
                    data_q[i]  <= data_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                    last_q[i]  <= last_q[i-1];
                end
            end
        end

        assign tap_data_o  = data_q[D-1];
        assign tap_valid_o = valid_q[D-1];
        assign tap_last_o  = last_q[D-1];
    end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Accepts LANES-wide operand vectors and drives one PE array edge with diagonal skew,
// one wavefront every BEAT_INTERVAL cycles, flushing the skew after the last vector.
module systolic_edge_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned LANES         = 4,
    parameter int unsigned BEAT_INTERVAL = 6
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0] s_data_i,
    input  logic                        s_last_i,
    output logic [LANES*DATA_WIDTH-1:0] lane_data_o,
    output logic [LANES-1:0]            lane_valid_o,
    output logic [LANES-1:0]            lane_last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    if (BEAT_INTERVAL < MIN_PE_TURNAROUND) begin : g_bad_interval
        $error("BEAT_INTERVAL must be at least MIN_PE_TURNAROUND");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("LANES must be at least 1");
    end

    localparam int unsigned    CntW      = (BEAT_INTERVAL > 1) ? $clog2(BEAT_INTERVAL) : 1;
    localparam int unsigned    RemW      = $clog2(LANES + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(BEAT_INTERVAL - 1);
    localparam logic [RemW-1:0] RemInit   = RemW'(LANES - 1);

    feeder_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic            done_q, done_d;

    logic [LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]            valid_q, valid_d;
    logic [LANES-1:0]            last_q, last_d;

    logic [LANES*DATA_WIDTH-1:0] tap_data;
    logic [LANES-1:0]            tap_valid;
    logic [LANES-1:0]            tap_last;

    logic tick;
    logic hs;
    logic push;

    assign tick      = (cnt_q == '0);
    assign s_ready_o = tick & ((state_q == IDLE) | (state_q == FEED));
    assign hs        = s_valid_i & s_ready_o;

    // Lane r sees each wavefront r ticks after lane 0, giving the diagonal skew.
    for (genvar r = 0; r < LANES; r++) begin : g_lane
        skew_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (r)
        ) u_skew (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .shift_en_i (push),
            .data_i     (s_data_i[r*DATA_WIDTH +: DATA_WIDTH]),
            .valid_i    (hs),
            .last_i     (s_last_i),
            .tap_data_o (tap_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .tap_valid_o(tap_valid[r]),
            .tap_last_o (tap_last[r])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hs) begin
                    push  = 1'b1;
                    cnt_d = CntReload;
                    if (s_last_i) begin
                        state_d = FLUSH;
                        rem_d   = RemInit;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (tick) begin
                    push  = 1'b1;
                    cnt_d = CntReload;
                    if (hs && s_last_i) begin
                        state_d = FLUSH;
                        rem_d   = RemInit;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            FLUSH: begin
                // Last lane's final beat was issued the previous cycle; finish now.
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    push  = 1'b1;
                    cnt_d = CntReload;
                    rem_d = rem_q - RemW'(1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Data only reloads on a real beat so it stays stable for the PE's late sample.
    always_comb begin
        valid_d = '0;
        last_d  = '0;
        data_d  = data_q;
        if (push) begin
            valid_d = tap_valid;
            last_d  = tap_valid & tap_last;
            for (int r = 0; r < int'(LANES); r++) begin
                if (tap_valid[r]) begin
                    data_d[r*DATA_WIDTH +: DATA_WIDTH] = tap_data[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign lane_data_o  = data_q;
    assign lane_valid_o = valid_q;
    assign lane_last_o  = last_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed, table-driven bench for systolic_edge_feeder (4-lane and 1-lane builds).
module tb_systolic_edge_feeder;

    localparam int BI = 6;

    typedef struct {
        logic [127:0] data;
        bit           last;
        int           gap;
        int           exp_acc;
    } vec_t;

    typedef struct {
        int          lane;
        int          cyc;
        logic [31:0] data;
        logic        last;
    } ev_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         s_valid;
    logic         s_ready_o;
    logic [127:0] s_data;
    logic         s_last;
    logic [127:0] lane_data_o;
    logic [3:0]   lane_valid_o;
    logic [3:0]   lane_last_o;
    logic         busy_o;
    logic         done_o;

    logic         one_valid;
    logic         one_ready;
    logic [31:0]  one_data;
    logic         one_last;
    logic [31:0]  one_lane_data;
    logic [0:0]   one_lane_valid;
    logic [0:0]   one_lane_last;
    logic         one_busy;
    logic         one_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stab_bad = 0;
    int proto_bad = 0;

    ev_t  ev_log[$];
    int   done_log[$];
    ev_t  one_log[$];
    int   one_done_log[$];
    vec_t vecs[$];

    int          since[4] = '{99, 99, 99, 99};
    logic [31:0] held[4];

    systolic_edge_feeder #(
        .DATA_WIDTH   (32),
        .LANES        (4),
        .BEAT_INTERVAL(BI)
    ) u_dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .lane_data_o (lane_data_o),
        .lane_valid_o(lane_valid_o),
        .lane_last_o (lane_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    systolic_edge_feeder #(
        .DATA_WIDTH   (32),
        .LANES        (1),
        .BEAT_INTERVAL(4)
    ) u_one (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .s_valid_i   (one_valid),
        .s_ready_o   (one_ready),
        .s_data_i    (one_data),
        .s_last_i    (one_last),
        .lane_data_o (one_lane_data),
        .lane_valid_o(one_lane_valid),
        .lane_last_o (one_lane_last),
        .busy_o      (one_busy),
        .done_o      (one_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (!rstn) begin
                since[r] = 99;
            end else if (lane_valid_o[r]) begin
                ev_log.push_back('{r, cyc, lane_data_o[r*32 +: 32], lane_last_o[r]});
                held[r]  = lane_data_o[r*32 +: 32];
                since[r] = 1;
            end else begin
                if (since[r] < BI && lane_data_o[r*32 +: 32] !== held[r]) stab_bad++;
                if (since[r] < 99) since[r]++;
            end
            if (lane_last_o[r] && !lane_valid_o[r]) proto_bad++;
        end
        if (done_o) begin
            done_log.push_back(cyc);
            if (lane_last_o[3]) proto_bad++;
        end
        if (one_lane_valid[0]) one_log.push_back('{0, cyc, one_lane_data, one_lane_last[0]});
        if (one_done) one_done_log.push_back(cyc);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [127:0] d, input bit l, output int t);
        t       = -1;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 20; i++) begin
            if (s_ready_o) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) check("accept timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int exp_done_off, input bit hold);
        int t0;
        int t;
        int rdy;
        t0 = 0;
        ev_log.delete();
        done_log.delete();
        foreach (vecs[i]) begin
            repeat (vecs[i].gap * BI) @(negedge clk);
            send(vecs[i].data, vecs[i].last, t);
            if (i == 0) t0 = t;
            check($sformatf("%s v%0d accept", tag, i), t - t0, vecs[i].exp_acc);
        end
        if (hold) begin
            s_valid = 1'b1;
            s_data  = {4{32'hDEAD_BEEF}};
            s_last  = 1'b1;
            rdy     = 0;
            repeat (17) begin
                @(negedge clk);
                if (s_ready_o) rdy++;
            end
            check({tag, " busy in flush"}, busy_o, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            check({tag, " ready in flush"}, rdy, 0);
            repeat (7) @(negedge clk);
        end else begin
            repeat (24) @(negedge clk);
        end
        check({tag, " busy after"}, busy_o, 0);
        check({tag, " done count"}, done_log.size(), 1);
        if (done_log.size() > 0) check({tag, " done time"}, done_log[0] - t0, exp_done_off);
        check({tag, " beat count"}, ev_log.size(), 4 * vecs.size());
        foreach (vecs[i]) begin
            for (int r = 0; r < 4; r++) begin
                int          ec;
                bit          found;
                logic [31:0] gd;
                logic        gl;
                ec    = t0 + vecs[i].exp_acc + 1 + BI * r;
                found = 0;
                gd    = '0;
                gl    = 1'b0;
                foreach (ev_log[j]) begin
                    if (ev_log[j].lane == r && ev_log[j].cyc == ec) begin
                        found = 1;
                        gd    = ev_log[j].data;
                        gl    = ev_log[j].last;
                    end
                end
                check($sformatf("%s v%0d lane%0d present", tag, i, r), found, 1);
                if (found) begin
                    check($sformatf("%s v%0d lane%0d data", tag, i, r), gd,
                          vecs[i].data[r*32 +: 32]);
                    check($sformatf("%s v%0d lane%0d last", tag, i, r), gl, vecs[i].last);
                end
            end
        end
    endtask

    task automatic load_single();
        vecs.delete();
        vecs.push_back('{128'h00000004_00000003_00000002_00000001, 1'b1, 0, 0});
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int ta;
        int tb;
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        one_valid = 1'b0;
        one_data  = '0;
        one_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset lane_valid", lane_valid_o, 0);
        check("reset lane_last", lane_last_o, 0);
        check("reset lane_data", lane_data_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle ready", s_ready_o, 1);

        // Single last vector, with upstream holding valid during the flush.
        load_single();
        run_stream("t1", 20, 1'b1);

        // Three back-to-back vectors.
        vecs.delete();
        vecs.push_back('{128'h00000013_00000012_00000011_00000010, 1'b0, 0, 0});
        vecs.push_back('{128'h00000023_00000022_00000021_00000020, 1'b0, 0, 6});
        vecs.push_back('{128'h00000033_00000032_00000031_00000030, 1'b1, 0, 12});
        run_stream("t2", 32, 1'b0);

        // Valid dropped on the second FEED tick: one bubble wavefront.
        vecs.delete();
        vecs.push_back('{128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b0, 0, 0});
        vecs.push_back('{128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1'b0, 1, 12});
        vecs.push_back('{128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 1'b1, 0, 18});
        run_stream("t3", 38, 1'b0);

        // Reset in the middle of FLUSH.
        load_single();
        send(vecs[0].data, vecs[0].last, t);
        repeat (9) @(negedge clk);
        check("t5 busy before reset", busy_o, 1);
        #2 rstn = 1'b0;
        #1;
        check("t5 reset lane_data", lane_data_o, 0);
        check("t5 reset lane_valid", lane_valid_o, 0);
        check("t5 reset busy", busy_o, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        ev_log.delete();
        done_log.delete();
        repeat (30) @(negedge clk);
        check("t5 no beats after reset", ev_log.size(), 0);
        check("t5 no done after reset", done_log.size(), 0);
        load_single();
        run_stream("t5 rerun", 20, 1'b0);

        // Single-lane build, BEAT_INTERVAL 4.
        one_log.delete();
        one_done_log.delete();
        check("t6 idle ready", one_ready, 1);
        one_valid = 1'b1;
        one_data  = 32'h0000_000A;
        one_last  = 1'b0;
        ta        = cyc;
        @(negedge clk);
        one_data = 32'h0000_000B;
        one_last = 1'b1;
        tb       = -1;
        for (int i = 0; i < 10; i++) begin
            if (one_ready) begin
                tb = cyc;
                break;
            end
            @(negedge clk);
        end
        check("t6 second accept", tb - ta, 4);
        @(negedge clk);
        one_valid = 1'b0;
        one_last  = 1'b0;
        repeat (5) @(negedge clk);
        check("t6 beat count", one_log.size(), 2);
        if (one_log.size() == 2) begin
            check("t6 beat0 time", one_log[0].cyc - ta, 1);
            check("t6 beat0 data", one_log[0].data, 32'hA);
            check("t6 beat0 last", one_log[0].last, 0);
            check("t6 beat1 time", one_log[1].cyc - ta, 5);
            check("t6 beat1 data", one_log[1].data, 32'hB);
            check("t6 beat1 last", one_log[1].last, 1);
        end
        check("t6 done count", one_done_log.size(), 1);
        if (one_done_log.size() == 1) check("t6 done time", one_done_log[0] - ta, 6);
        check("t6 busy after", one_busy, 0);

        check("data stable after beat", stab_bad, 0);
        check("last/done protocol", proto_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
